// File: rtl/seq_addsub_32_pkg.sv
// Shared encodings for the two-cycle, time-multiplexed 32-bit add/subtract unit.
package seq_addsub_32_pkg;

    localparam int unsigned HALF_W = 16;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/cla_16_bit.sv
// 16-bit carry-lookahead adder: four 4-bit groups with group generate/propagate
// feeding a lookahead carry chain across the groups.
module cla_16_bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    always_comb begin
        logic [15:0] g;
        logic [15:0] p;
        logic        gg;
        logic        gp;
        logic        cg;
        logic        cc;

        g   = a & b;
        p   = a ^ b;
        sum = '0;
        cg  = cin;
        for (int k = 0; k < 4; k++) begin
            gg = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | ((&p[4*k+1 +: 3]) & g[4*k]);
            gp = &p[4*k +: 4];
            // In-group carries ripple from the group carry-in; groups use lookahead.
            cc = cg;
            for (int j = 0; j < 4; j++) begin
                sum[4*k+j] = p[4*k+j] ^ cc;
                cc         = g[4*k+j] | (p[4*k+j] & cc);
            end
            cg = gg | (gp & cg);
        end
        cout = cg;
    end

endmodule

// File: rtl/seq_addsub_32.sv
// Multi-cycle 32-bit add/subtract: one 16-bit CLA slice used for the low half, then the high half.
// Define SEQ_ADDSUB_FLAGS_EN to build the overflow/zero/negative flag logic; otherwise they read 0.
module seq_addsub_32
    import seq_addsub_32_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned HALF  = HALF_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    if (WIDTH != 32 || HALF != HALF_W) begin : gen_width_check
        $error("seq_addsub_32 supports only WIDTH=32 with a 16-bit slice");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               cin_q, cin_d;
    logic               c16_q, c16_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;

    logic [HALF-1:0]    slice_a;
    logic [HALF-1:0]    slice_b;
    logic               slice_cin;
    logic [HALF-1:0]    slice_sum;
    logic               slice_cout;

    // Slice inputs only matter in LO and HI; anything other than LO selects the high half.
    always_comb begin
        if (state_q == ST_LO) begin
            slice_a   = a_q[HALF-1:0];
            slice_b   = b_q[HALF-1:0];
            slice_cin = cin_q;
        end else begin
            slice_a   = a_q[WIDTH-1:HALF];
            slice_b   = b_q[WIDTH-1:HALF];
            slice_cin = c16_q;
        end
    end

    cla_16_bit u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (slice_cin),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        cin_d    = cin_q;
        c16_d    = c16_q;
        result_d = result_q;
        carry_d  = carry_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = (op_sub == OP_SUB) ? ~b : b;
                    cin_d   = op_sub;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                result_d[HALF-1:0] = slice_sum;
                c16_d              = slice_cout;
                state_d            = ST_HI;
            end
            ST_HI: begin
                result_d[WIDTH-1:HALF] = slice_sum;
                carry_d                = slice_cout;
                state_d                = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            c16_q    <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cin_q    <= cin_d;
            c16_q    <= c16_d;
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign carry     = carry_q;

`ifdef SEQ_ADDSUB_FLAGS_EN
    logic overflow_q, overflow_d;
    logic zero_q, zero_d;
    logic negative_q, negative_d;

    // b_q already holds the inverted operand for subtract, so one overflow rule covers both ops.
    always_comb begin
        overflow_d = overflow_q;
        zero_d     = zero_q;
        negative_d = negative_q;
        if (state_q == ST_HI) begin
            overflow_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_sum[HALF-1] != a_q[WIDTH-1]);
            zero_d     = ({slice_sum, result_q[HALF-1:0]} == '0);
            negative_d = slice_sum[HALF-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
            negative_q <= negative_d;
        end
    end

    assign overflow = overflow_q;
    assign zero     = zero_q;
    assign negative = negative_q;
`else
    assign overflow = 1'b0;
    assign zero     = 1'b0;
    assign negative = 1'b0;
`endif

endmodule

// File: tb/tb_seq_addsub_32.sv
// Scoreboard bench for seq_addsub_32: directed vectors, handshake/backpressure and mid-op reset.
module tb_seq_addsub_32;

`ifdef SEQ_ADDSUB_FLAGS_EN
    localparam bit FlagsEn = 1'b1;
`else
    localparam bit FlagsEn = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] res;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        op_sub = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        carry;
    logic        overflow;
    logic        zero;
    logic        negative;

    int n_cmp = 0;
    int n_err = 0;
    exp_t exp_q[$];

    seq_addsub_32 u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: every output handshake pops one expected response.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got result %h with nothing expected", result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", result, e.res);
                check("carry", {31'd0, carry}, {31'd0, e.c});
                check("overflow", {31'd0, overflow}, {31'd0, e.v & FlagsEn});
                check("zero", {31'd0, zero}, {31'd0, e.z & FlagsEn});
                check("negative", {31'd0, negative}, {31'd0, e.n & FlagsEn});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, push its expected response, return just after the accept edge.
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                         input logic [31:0] eres, input logic ec, input logic ev,
                         input logic ez, input logic en);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!in_ready) check("issue_timeout", 32'd0, 32'd1);
        in_valid = 1'b1;
        a        = ia;
        b        = ib;
        op_sub   = isub;
        exp_q.push_back('{res: eres, c: ec, v: ev, z: ez, n: en});
        tick();
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        op_sub   = 1'($urandom_range(1));
    endtask

    task automatic wait_valid();
        int cnt = 0;
        while (!out_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        check("latency_edges", cnt, 32'd2);
    endtask

    // Full operation with out_ready already high: result, then IDLE on the next edge.
    task automatic run(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                       input logic [31:0] eres, input logic ec, input logic ev,
                       input logic ez, input logic en);
        issue(ia, ib, isub, eres, ec, ev, ez, en);
        wait_valid();
        tick();
        check("in_ready_after", {31'd0, in_ready}, 32'd1);
        check("out_valid_after", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_carry", {31'd0, carry}, 32'd0);
        check("rst_flags", {29'd0, overflow, zero, negative}, 32'd0);
        #10;
        rst = 1'b1;
        tick();

        run(32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        run(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
        run(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
        run(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        run(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
        run(32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);

        // Backpressure, with a competing request held during LO/HI/DONE.
        out_ready = 1'b0;
        issue(32'h1234_5678, 32'h0000_0001, 1'b1, 32'h1234_5677, 1'b1, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        a        = 32'hFFFF_FFFF;
        b        = 32'hFFFF_FFFF;
        op_sub   = 1'b0;
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_result", result, 32'h1234_5677);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("pulse_out_valid", {31'd0, out_valid}, 32'd0);
        check("pulse_in_ready", {31'd0, in_ready}, 32'd1);

        // Asynchronous reset while in HI discards the pending result.
        issue(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        #2;
        rst = 1'b0;
        void'(exp_q.pop_back());
        #1;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_carry", {31'd0, carry}, 32'd0);
        #3;
        rst = 1'b1;
        tick();
        run(32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 1'b0);

        tick();
        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_addsub_32.md
Name: seq_addsub_32

Overview:
- Multi-cycle 32-bit add/subtract unit for the ALU stage.
- Time-multiplexes one 16-bit carry-lookahead slice over two cycles: low half first, then high half with the registered inter-half carry.
- Sits between the operand-fetch/decode stage (upstream, valid/ready) and the writeback/flags logic (downstream, valid/ready).
- Trades one adder slice for 3-cycle latency.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported (2 x 16-bit slice); any other value is a compile-time error.
- HALF, 16, slice width; fixed, not overridable in practice.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- in_valid  in  1  operands and op presented
- in_ready  out  1  unit can accept a request
- op_sub  in  1  0 = a+b, 1 = a-b
- a  in  32  operand A
- b  in  32  operand B
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer accepts the result
- result  out  32  sum/difference modulo 2^32
- carry  out  1  carry out of bit 31; for subtract, 1 means no borrow
- overflow  out  1  signed overflow
- zero  out  1  result == 0
- negative  out  1  result[31]

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; result=0; carry=0; overflow=0; zero=0; negative=0; out_valid=0; in_ready=1; internal operand and carry registers = 0.
- States: IDLE, LO, HI, DONE.
- Outputs per state:
  - in_ready=1 only in IDLE.
  - out_valid=1 only in DONE.
- IDLE: on in_valid && in_ready at a clock edge:
  - latch a, b' = op_sub ? ~b : b, and cin0 = op_sub.
  - go to LO.
- LO: slice computes a[15:0] + b'[15:0] + cin0.
  - Register the sum into result[15:0] and the slice carry-out into c16.
  - Go to HI.
- HI: slice computes a[31:16] + b'[31:16] + c16.
  - Register the sum into result[31:16].
  - carry = slice carry-out.
  - overflow = (a[31] == b'[31]) && (sum[31] != a[31]).
  - zero and negative are computed from the full 32-bit result.
  - Go to DONE.
- DONE: hold all outputs stable until out_ready=1 at a clock edge, then go to IDLE.
  - in_ready rises the cycle after the handshake; there is no same-cycle re-accept.
- Latency: accept edge E0 -> out_valid high after edge E2 (3rd cycle). Throughput: one operation per 4 cycles when out_ready is held high.
- out_valid remains high and outputs remain stable under backpressure (out_ready=0) indefinitely.
- in_valid while not in IDLE is ignored; upstream holds the request until in_ready.
- Operand changes after the accept edge have no effect.
- Reset asserted mid-operation (LO/HI/DONE) aborts immediately to reset values; the pending result is discarded.
- Arithmetic is unsigned modulo 2^32; carry and overflow are both always produced.
- The slice is purely combinational. Its inputs are muxed by state: low halves in LO, high halves in HI. In IDLE/DONE the inputs are don't-care.

Optional Feature:
- Macro: SEQ_ADDSUB_FLAGS_EN.
- Defined: overflow, zero and negative are computed and registered as above.
- Not defined: overflow, zero and negative are tied to 0 with no flag logic synthesized; result and carry are unaffected.

Decomposition:
- Shared package:
  - state encoding constants ST_IDLE=2'd0, ST_LO=2'd1, ST_HI=2'd2, ST_DONE=2'd3.
  - OP_ADD=1'b0, OP_SUB=1'b1.
  - HALF_W=16.
- One sub-module, natural and reused: the team's existing cla_16_bit, instantiated exactly once as the shared slice.
- FSM, operand registers and flag logic stay in this module.

Test Plan:
- Basic add: a=32'h0000_FFFF, b=32'h0000_0001, op_sub=0 -> after 3 cycles result=32'h0001_0000, carry=0, zero=0, overflow=0. Confirms the inter-half carry.
- Wrap/carry: a=32'hFFFF_FFFF, b=1, add -> result=0, carry=1, zero=1, overflow=0, negative=0.
- Subtract/overflow: a=32'h8000_0000, b=1, op_sub=1 -> result=32'h7FFF_FFFF, carry=1, overflow=1, negative=0.
- Subtract with borrow: a=5, b=7, op_sub=1 -> result=32'hFFFF_FFFE, carry=0, negative=1, overflow=0.
- Backpressure and handshake:
  - hold out_ready=0 for 5 cycles -> out_valid and result stable, in_ready=0 throughout.
  - pulse out_ready -> out_valid=0 and in_ready=1 on the next cycle.
  - a new request during HI is ignored.
- Reset mid-op: assert rst=0 asynchronously while in HI -> outputs immediately reset values, in_ready=1.
  - After release, a=1, b=2, add -> result=3.
